seg7_scan_display: RTL and testbench
====================================

// Module: seg7_scan_display
// PURPOSE
//  - Time-multiplexed 8-digit seven-segment driver; consumes the registered ALU result and PC values from the CPU top level.
//  - Drives the board's shared segment bus and common-anode digit enables.
//  - Double-buffered: new values are captured at any time but committed only at a frame boundary, so the display never tears.
// PARAMETERS
//  - REFRESH_DIV  100000  Clk cycles each digit stays lit (>=1); frame = 8*REFRESH_DIV cycles
// PORTS
//  - Clk        in   1   system clock; single clock domain
//  - Rst        in   1   synchronous, active-high reset
//  - Load       in   1   1-cycle strobe; capture NumberA/NumberB into pending regs
//  - NumberA    in   32  value for digits 7..4 (hex of NumberA[15:0])
//  - NumberB    in   32  value for digits 3..0 (hex of NumberB[15:0])
//  - out7       out  7   segments {g,f,e,d,c,b,a}, active-low
//  - en_out     out  8   digit enables, active-low; bit i = digit i
//  - FrameDone  out  1   1-cycle pulse when the scan wraps from digit 7 to digit 0
// BEHAVIOUR
//  - Reset: refresh ctr=0, digit idx=0, pending regs=0, pend_vld=0, display regs=0.
//  - Reset outputs: en_out=8'hFE, out7=7'h40 ("0"), FrameDone=0.
//  - Refresh ctr counts 0..REFRESH_DIV-1 and wraps; wrap cycle = tick.
//  - On tick: idx <= idx+1 (mod 8); 7->0 is the frame boundary.
//  - Frame boundary, same edge:
//    - FrameDone <= 1 (otherwise 0).
//    - If pend_vld: display regs <= pending regs and pend_vld <= 0.
//  - Load: pending <= {NumberA[15:0],NumberB[15:0]}; pend_vld <= 1; last Load before a boundary wins.
//  - Load on the boundary cycle: the Load values commit directly to the display regs; pend_vld ends 0.
//  - Digit map:
//    - Digit i<4 shows nibble NumberB[4i+3:4i].
//    - Digit i>=4 shows nibble NumberA[4(i-4)+3:4(i-4)].
//  - out7/en_out are registered from (idx, display regs); they follow an idx change by exactly 1 cycle.
//  - en_out has exactly one 0 bit at all times; en_out = ~(8'b1 << idx_delayed).
//  - Hex->out7 codes (7-bit hex):
//    - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//    - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E; blank=7F
//  - REFRESH_DIV=1: idx advances every cycle and FrameDone fires every 8 cycles.
//  - Rst mid-frame: everything returns to reset values on the next edge; pending Loads are discarded.
//  - Upper bits NumberA[31:16] and NumberB[31:16] are ignored.
// CONFIGURATION
//  - Macro LEADING_ZERO_BLANK_EN.
//  - Defined: leading-zero blanking within each 4-digit group, evaluated on the display regs.
//    - Digits 7,6,5 blank (out7=7F) while they and all higher digits of the group are 0; same for digits 3,2,1.
//    - Digits 4 and 0 are never blanked; en_out is unchanged.
//  - Undefined: all 8 digits always show their hex nibble; the blanking logic is absent.
// TESTING (REFRESH_DIV=4 unless noted)
//  - Reset scan:
//    - Rst 1 cycle, no Load -> en_out=FE, out7=40.
//    - en_out steps FE,FD,FB,...,7F with each value held 4 cycles.
//    - FrameDone pulses once per 32 cycles, on the wrap edge.
//  - Double buffering:
//    - Load A=0x1234,B=0xABCD at idx=2 -> digits keep showing 0 until the boundary.
//    - Next frame: digit7=79 ... digit4=19, digit3=08, digit0=21.
//  - Simultaneous events:
//    - Load on the FrameDone edge -> the new value is shown from digit 0 of that frame.
//    - Two Loads in one frame -> only the second is displayed.
//  - Mid-frame reset:
//    - Assert Rst at idx=5 with a pending Load -> outputs return to FE/40.
//    - The pending value is never displayed.
//  - REFRESH_DIV=1 -> en_out changes every cycle; FrameDone period is 8 cycles.
//  - With LEADING_ZERO_BLANK_EN: A=0x0005, B=0x0000 -> digits 7,6,5,3,2,1 show 7F; digit4=12, digit0=40.

Source files
------------

// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed seven-segment driver with a frame-aligned double buffer.
// Optional LEADING_ZERO_BLANK_EN blanks leading zeros within each 4-digit group.
module seg7_scan_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Load,
  input  logic [31:0] NumberA,
  input  logic [31:0] NumberB,
  output logic [6:0]  out7,
  output logic [7:0]  en_out,
  output logic        FrameDone
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   pend;
  logic [31:0]   disp;
  logic          pend_vld;
  logic          tick;
  logic          boundary;
  logic [31:0]   load_val;
  logic [3:0]    nib;
  logic [6:0]    seg;
  logic          unused_hi;

  assign load_val  = {NumberA[15:0], NumberB[15:0]};
  assign unused_hi = ^{NumberA[31:16], NumberB[31:16]};
  assign tick      = (cnt == CW'(REFRESH_DIV - 1));
  assign boundary  = tick && (idx == 3'd7);

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] blank;

  // Blanking chains downward from the top digit of each group.
  always_comb begin
    blank    = '0;
    blank[7] = (disp[31:28] == 4'h0);
    blank[6] = blank[7] && (disp[27:24] == 4'h0);
    blank[5] = blank[6] && (disp[23:20] == 4'h0);
    blank[3] = (disp[15:12] == 4'h0);
    blank[2] = blank[3] && (disp[11:8] == 4'h0);
    blank[1] = blank[2] && (disp[7:4] == 4'h0);
  end

  always_comb begin
    nib = disp[{idx, 2'b00} +: 4];
    seg = hex7(nib);
    if (blank[idx]) seg = 7'h7F;
  end
`else
  always_comb begin
    nib = disp[{idx, 2'b00} +: 4];
    seg = hex7(nib);
  end
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt       <= '0;
      idx       <= '0;
      pend      <= '0;
      pend_vld  <= 1'b0;
      disp      <= '0;
      FrameDone <= 1'b0;
      en_out    <= 8'hFE;
      out7      <= 7'h40;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 3'd1;
      FrameDone <= boundary;
      if (Load) pend <= load_val;
      // A Load landing on the boundary bypasses the pending stage.
      if (boundary && Load)
        disp <= load_val;
      else if (boundary && pend_vld)
        disp <= pend;
      if (boundary)
        pend_vld <= 1'b0;
      else if (Load)
        pend_vld <= 1'b1;
      en_out <= ~(8'b1 << idx);
      out7   <= seg;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display (REFRESH_DIV=4 and REFRESH_DIV=1 instances).
// Build with +define+LEADING_ZERO_BLANK_EN to cover the blanking variant.
module tb_seg7_scan_display;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Load = 1'b0;
  logic [31:0] NumberA = '0;
  logic [31:0] NumberB = '0;
  logic [6:0]  out7;
  logic [7:0]  en_out;
  logic        FrameDone;
  logic [6:0]  out7_f;
  logic [7:0]  en_out_f;
  logic        FrameDone_f;

  int errors = 0;
  int checks = 0;
  int k = 0;

  logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                           7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                           7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 Clk = ~Clk;

  seg7_scan_display #(.REFRESH_DIV(4)) dut (
    .Clk(Clk), .Rst(Rst), .Load(Load),
    .NumberA(NumberA), .NumberB(NumberB),
    .out7(out7), .en_out(en_out), .FrameDone(FrameDone)
  );

  seg7_scan_display #(.REFRESH_DIV(1)) dut_f (
    .Clk(Clk), .Rst(Rst), .Load(Load),
    .NumberA(NumberA), .NumberB(NumberB),
    .out7(out7_f), .en_out(en_out_f), .FrameDone(FrameDone_f)
  );

  function automatic int dig(int kk, int div);
    return (kk == 0) ? 0 : ((kk - 1) / div) % 8;
  endfunction

  function automatic logic [7:0] en_exp(int kk, int div);
    logic [7:0] one;
    one = 8'b1;
    return ~(one << dig(kk, div));
  endfunction

  function automatic logic [6:0] zexp(int d);
`ifdef LEADING_ZERO_BLANK_EN
    return (d == 0 || d == 4) ? 7'h40 : 7'h7F;
`else
    return (d >= 0) ? 7'h40 : 7'h40;
`endif
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
    k++;
  endtask

  task automatic go(int t);
    while (k < t) step();
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    Load = 1'b0;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    k = 0;
  endtask

  // Load is sampled on edge t+1 after reset.
  task automatic load_at(int t, logic [31:0] a, logic [31:0] b);
    go(t);
    Load = 1'b1;
    NumberA = a;
    NumberB = b;
    step();
    Load = 1'b0;
    NumberA = 32'hDEAD_BEEF;
    NumberB = 32'hCAFE_F00D;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (en_out !== 8'hFE) begin
      errors++;
      $display("FAIL reset_en got=%h exp=fe", en_out);
    end
    checks++;
    if (out7 !== 7'h40) begin
      errors++;
      $display("FAIL reset_out7 got=%h exp=40", out7);
    end
    checks++;
    if (FrameDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_fd got=%b exp=0", FrameDone);
    end
  endtask

  task automatic test_scan();
    do_reset();
    for (int t = 1; t <= 70; t++) begin
      step();
      checks++;
      if (en_out !== en_exp(k, 4)) begin
        errors++;
        $display("FAIL scan_en k=%0d got=%h exp=%h", k, en_out, en_exp(k, 4));
      end
      checks++;
      if (FrameDone !== (k % 32 == 0)) begin
        errors++;
        $display("FAIL scan_fd k=%0d got=%b exp=%b", k, FrameDone, k % 32 == 0);
      end
      checks++;
      if (out7 !== zexp(dig(k, 4))) begin
        errors++;
        $display("FAIL scan_out7 k=%0d got=%h exp=%h", k, out7, zexp(dig(k, 4)));
      end
    end
  endtask

  task automatic test_double_buffer();
    logic [31:0] v;
    v = 32'h1234_ABCD;
    do_reset();
    load_at(9, 32'hFFFF_1234, 32'h5555_ABCD);
    while (k < 32) begin
      step();
      checks++;
      if (out7 !== zexp(dig(k, 4))) begin
        errors++;
        $display("FAIL dbuf_hold k=%0d got=%h exp=%h", k, out7, zexp(dig(k, 4)));
      end
    end
    for (int d = 0; d < 8; d++) begin
      go(33 + 4 * d);
      checks++;
      if (out7 !== SEG[v[4*d +: 4]]) begin
        errors++;
        $display("FAIL dbuf_show d=%0d got=%h exp=%h", d, out7, SEG[v[4*d +: 4]]);
      end
    end
  endtask

  task automatic test_load_on_boundary();
    logic [31:0] v;
    v = 32'h9876_5E0F;
    do_reset();
    load_at(10, 32'h1111, 32'h1111);
    load_at(31, 32'h0000_9876, 32'h0000_5E0F);
    checks++;
    if (FrameDone !== 1'b1) begin
      errors++;
      $display("FAIL bnd_fd got=%b exp=1", FrameDone);
    end
    for (int d = 0; d < 8; d++) begin
      go(33 + 4 * d);
      checks++;
      if (out7 !== SEG[v[4*d +: 4]]) begin
        errors++;
        $display("FAIL bnd_show d=%0d got=%h exp=%h", d, out7, SEG[v[4*d +: 4]]);
      end
    end
  endtask

  task automatic test_two_loads();
    logic [31:0] v;
    logic [6:0]  e;
    v = 32'h00C0_7B08;
    do_reset();
    load_at(5, 32'h1111, 32'h2222);
    load_at(20, 32'h00C0, 32'h7B08);
    for (int d = 0; d < 8; d++) begin
      go(33 + 4 * d);
      e = SEG[v[4*d +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
      if (d >= 6) e = 7'h7F;
`endif
      checks++;
      if (out7 !== e) begin
        errors++;
        $display("FAIL two_loads d=%0d got=%h exp=%h", d, out7, e);
      end
    end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    load_at(10, 32'h8888, 32'h8888);
    go(21);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    k = 0;
    checks++;
    if (en_out !== 8'hFE || out7 !== 7'h40 || FrameDone !== 1'b0) begin
      errors++;
      $display("FAIL midrst en=%h out7=%h fd=%b exp=fe/40/0", en_out, out7, FrameDone);
    end
    for (int d = 0; d < 8; d++) begin
      go(33 + 4 * d);
      checks++;
      if (out7 !== zexp(d)) begin
        errors++;
        $display("FAIL midrst_show d=%0d got=%h exp=%h", d, out7, zexp(d));
      end
    end
  endtask

  task automatic test_fast_refresh();
    do_reset();
    for (int t = 1; t <= 24; t++) begin
      step();
      checks++;
      if (en_out_f !== en_exp(k, 1)) begin
        errors++;
        $display("FAIL fast_en k=%0d got=%h exp=%h", k, en_out_f, en_exp(k, 1));
      end
      checks++;
      if (FrameDone_f !== (k % 8 == 0)) begin
        errors++;
        $display("FAIL fast_fd k=%0d got=%b exp=%b", k, FrameDone_f, k % 8 == 0);
      end
    end
  endtask

  task automatic test_blank();
    logic [6:0] e [8];
`ifdef LEADING_ZERO_BLANK_EN
    e = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h7F, 7'h7F, 7'h7F};
`else
    e = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h12, 7'h40, 7'h40, 7'h40};
`endif
    do_reset();
    load_at(2, 32'h0000_0005, 32'h0000_0000);
    for (int d = 0; d < 8; d++) begin
      go(33 + 4 * d);
      checks++;
      if (out7 !== e[d]) begin
        errors++;
        $display("FAIL blank d=%0d got=%h exp=%h", d, out7, e[d]);
      end
      checks++;
      if (en_out !== en_exp(k, 4)) begin
        errors++;
        $display("FAIL blank_en d=%0d got=%h exp=%h", d, en_out, en_exp(k, 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_double_buffer();
    test_load_on_boundary();
    test_two_loads();
    test_midframe_reset();
    test_fast_refresh();
    test_blank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
